// File: rtl/riscv_pkg.sv
// Shared definitions for the instruction-memory loader: word width and loader FSM encoding.
// Pure constants; no logic, no latency, no flow control.
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LEN0  = 3'd1;
  localparam logic [2:0] ST_LEN1  = 3'd2;
  localparam logic [2:0] ST_DATA  = 3'd3;
  localparam logic [2:0] ST_WRITE = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;
  localparam logic [2:0] ST_ERROR = 3'd6;

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Packs little-endian bytes into a 32-bit word; word_last flags the 4th byte combinationally,
// word_rdy holds from then until clear. Accepts a byte whenever byte_vld is high (no back-pressure).
module word_assembler
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            clear,
  input  logic            byte_vld,
  input  logic [7:0]      byte_dat,
  output logic [XLEN-1:0] word_dat,
  output logic            word_last,
  output logic            word_rdy
);

  logic [1:0]      cnt_q, cnt_d;
  logic [XLEN-1:0] word_q, word_d;
  logic            rdy_q, rdy_d;

  always_comb begin
    cnt_d     = cnt_q;
    word_d    = word_q;
    rdy_d     = rdy_q;
    word_last = byte_vld && (cnt_q == 2'd3);
    if (clear) begin
      cnt_d = 2'd0;
      rdy_d = 1'b0;
    end else if (byte_vld) begin
      word_d[{cnt_q, 3'b000} +: 8] = byte_dat;
      cnt_d = cnt_q + 2'd1;
      if (cnt_q == 2'd3) rdy_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= 2'd0;
      word_q <= '0;
      rdy_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      word_q <= word_d;
      rdy_q  <= rdy_d;
    end
  end

  assign word_dat = word_q;
  assign word_rdy = rdy_q;

endmodule

// File: rtl/imem_loader.sv
// Length-prefixed byte-stream loader writing 32-bit words into instruction memory; one write
// the cycle after each 4th byte (>=5 cycles/word). in_ready drops outside LEN0/LEN1/DATA and in WRITE.
module imem_loader
  import riscv_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        we,
  output logic [31:0] waddr,
  output logic [31:0] wdata,
  output logic        cpu_hold,
  output logic        done,
  output logic        error
);

  localparam int IDX_W = $clog2(MAX_WORDS + 1);

  logic [2:0]       state_q, state_d;
  logic [15:0]      count_q, count_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [15:0]      hdr_count;
  logic             byte_fire;
  logic             asm_clear, asm_vld, word_last, word_rdy;
  logic [XLEN-1:0]  word_dat;

  assign in_ready  = (state_q == ST_LEN0) || (state_q == ST_LEN1) || (state_q == ST_DATA);
  assign byte_fire = in_valid && in_ready;
  assign hdr_count = {in_data, count_q[7:0]};

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    idx_d     = idx_q;
    asm_clear = 1'b0;
    asm_vld   = 1'b0;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_LEN0;
      ST_LEN0: begin
        if (byte_fire) begin
          count_d[7:0] = in_data;
          state_d      = ST_LEN1;
        end
      end
      ST_LEN1: begin
        if (byte_fire) begin
          count_d[15:8] = in_data;
          if (hdr_count == 16'd0) begin
            state_d = ST_DONE;
          end else if (hdr_count > 16'(MAX_WORDS)) begin
            state_d = ST_ERROR;
          end else begin
            state_d   = ST_DATA;
            idx_d     = '0;
            asm_clear = 1'b1;
          end
        end
      end
      ST_DATA: begin
        asm_vld = byte_fire;
        if (word_last) state_d = ST_WRITE;
      end
      ST_WRITE: begin
        idx_d     = idx_q + 1'b1;
        asm_clear = 1'b1;
        state_d   = ((32'(idx_q) + 32'd1) == 32'(count_q)) ? ST_DONE : ST_DATA;
      end
      ST_DONE, ST_ERROR: begin
        // Restart rewinds the address so waddr reads BASE_ADDR again before the new header.
        if (start) begin
          state_d = ST_LEN0;
          idx_d   = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      count_q <= 16'd0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      idx_q   <= idx_d;
    end
  end

  word_assembler u_asm (
    .clk       (clk),
    .reset     (reset),
    .clear     (asm_clear),
    .byte_vld  (asm_vld),
    .byte_dat  (in_data),
    .word_dat  (word_dat),
    .word_last (word_last),
    .word_rdy  (word_rdy)
  );

  assign we       = (state_q == ST_WRITE) && word_rdy;
  assign waddr    = BASE_ADDR + (32'(idx_q) << 2);
  assign wdata    = word_dat;
  assign done     = (state_q == ST_DONE);
  assign error    = (state_q == ST_ERROR);
  assign cpu_hold = (state_q != ST_DONE);

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: random images and gaps checked against a byte-list reference model.
module tb_imem_loader;

  typedef logic [7:0]  bq_t[$];
  typedef logic [63:0] wq_t[$];

  logic        clk = 1'b0;
  logic        reset, start, in_valid, sel;
  logic [7:0]  in_data;
  logic        in_ready0, we0, cpu_hold0, done0, error0;
  logic [31:0] waddr0, wdata0;
  logic        in_ready1, we1, cpu_hold1, done1, error1;
  logic [31:0] waddr1, wdata1;
  int          checks = 0;
  int          errors = 0;
  wq_t         cap0, cap1;

  always #5 clk = ~clk;

  imem_loader #(.BASE_ADDR(32'h0000_0000), .MAX_WORDS(64)) dut0 (
    .clk(clk), .reset(reset), .start(start & ~sel), .in_valid(in_valid & ~sel),
    .in_data(in_data), .in_ready(in_ready0), .we(we0), .waddr(waddr0), .wdata(wdata0),
    .cpu_hold(cpu_hold0), .done(done0), .error(error0));

  imem_loader #(.BASE_ADDR(32'h0000_0100), .MAX_WORDS(64)) dut1 (
    .clk(clk), .reset(reset), .start(start & sel), .in_valid(in_valid & sel),
    .in_data(in_data), .in_ready(in_ready1), .we(we1), .waddr(waddr1), .wdata(wdata1),
    .cpu_hold(cpu_hold1), .done(done1), .error(error1));

  always @(negedge clk) begin
    if (we0 === 1'b1) cap0.push_back({waddr0, wdata0});
    if (we1 === 1'b1) cap1.push_back({waddr1, wdata1});
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  task automatic make_image(input int n, input logic [31:0] base, output bq_t b, output wq_t e);
    logic [31:0] w;
    b = {};
    e = {};
    b.push_back(n[7:0]);
    b.push_back(n[15:8]);
    for (int i = 0; i < n; i++) begin
      w = $urandom;
      for (int k = 0; k < 4; k++) b.push_back(w[8*k +: 8]);
      e.push_back({base + 32'(4 * i), w});
    end
  endtask

  task automatic pulse_start(input bit with_byte, input logic [7:0] b);
    @(negedge clk);
    start    = 1'b1;
    in_valid = with_byte;
    in_data  = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Each byte is held until a rising edge sees in_ready; returns at the negedge after the last accept.
  task automatic send_bytes(input bq_t bytes, input int gap_pct);
    logic r, w;
    int   t;
    foreach (bytes[i]) begin
      if ($urandom_range(99) < gap_pct) begin
        in_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
      in_valid = 1'b1;
      in_data  = bytes[i];
      t = 0;
      forever begin
        #4;
        r = sel ? in_ready1 : in_ready0;
        w = sel ? we1 : we0;
        if (w === 1'b1) begin
          checks++;
          if (r !== 1'b0) begin
            errors++;
            $display("FAIL ready_in_write: in_ready=%b during write, expected 0", r);
          end
        end
        @(posedge clk);
        @(negedge clk);
        if (r === 1'b1) break;
        t++;
        if (t > 50) begin
          errors++;
          $display("FAIL byte_timeout: byte %0d not accepted within 50 cycles, expected accept", i);
          in_valid = 1'b0;
          return;
        end
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic compare_writes(input wq_t got, input wq_t exp, input string name);
    checks++;
    if (got.size() != exp.size()) begin
      errors++;
      $display("FAIL %s_count: got %0d writes, expected %0d", name, got.size(), exp.size());
    end
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      checks++;
      if (got[i] !== exp[i]) begin
        errors++;
        $display("FAIL %s_word%0d: got addr=%h data=%h, expected addr=%h data=%h",
                 name, i, got[i][63:32], got[i][31:0], exp[i][63:32], exp[i][31:0]);
      end
    end
  endtask

  task automatic check_bit(input logic got, input logic exp, input string name);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b", name, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_bit(we0, 1'b0, {tag, "_we"});
    check_bit(in_ready0, 1'b0, {tag, "_in_ready"});
    check_bit(done0, 1'b0, {tag, "_done"});
    check_bit(error0, 1'b0, {tag, "_error"});
    check_bit(cpu_hold0, 1'b1, {tag, "_cpu_hold"});
    checks++;
    if (waddr0 !== 32'h0 || wdata0 !== 32'h0) begin
      errors++;
      $display("FAIL %s_addr_data: got waddr=%h wdata=%h, expected 0/0", tag, waddr0, wdata0);
    end
  endtask

  function automatic bq_t nominal_bytes();
    bq_t b = '{8'h04, 8'h00, 8'h03, 8'hA3, 8'hC4, 8'hFF, 8'h23, 8'hA4, 8'h64, 8'h00,
               8'h33, 8'hE2, 8'h62, 8'h00, 8'hE3, 8'h0A, 8'h42, 8'hFE};
    return b;
  endfunction

  function automatic wq_t nominal_words();
    wq_t e = '{{32'h0, 32'hFFC4A303}, {32'h4, 32'h0064A423},
               {32'h8, 32'h0062E233}, {32'hC, 32'hFE420AE3}};
    return e;
  endfunction

  task automatic test_reset();
    sel = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    reset = 1'b1;
    #2;
    check_reset_outputs("reset");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_bit(cpu_hold0, 1'b1, "idle_cpu_hold");
  endtask

  task automatic test_nominal(input int gap_pct, input string name);
    cap0 = {};
    pulse_start(1'b0, 8'h00);
    send_bytes(nominal_bytes(), gap_pct);
    check_bit(we0, 1'b1, {name, "_last_we"});
    @(negedge clk);
    check_bit(done0, 1'b1, {name, "_done"});
    check_bit(cpu_hold0, 1'b0, {name, "_cpu_hold"});
    compare_writes(cap0, nominal_words(), name);
  endtask

  task automatic test_zero_count();
    cap0 = {};
    pulse_start(1'b0, 8'h00);
    in_valid = 1'b1;
    in_data  = 8'h00;
    @(negedge clk);
    check_bit(done0, 1'b0, "zero_done_early");
    @(negedge clk);
    in_valid = 1'b0;
    check_bit(done0, 1'b1, "zero_done");
    repeat (2) @(negedge clk);
    checks++;
    if (cap0.size() != 0) begin
      errors++;
      $display("FAIL zero_we: got %0d writes, expected 0", cap0.size());
    end
  endtask

  task automatic test_overflow();
    bq_t b = '{8'h41, 8'h00};
    cap0 = {};
    pulse_start(1'b0, 8'h00);
    send_bytes(b, 0);
    check_bit(error0, 1'b1, "ovf_error");
    check_bit(cpu_hold0, 1'b1, "ovf_cpu_hold");
    in_valid = 1'b1;
    in_data  = 8'h5A;
    repeat (8) begin
      check_bit(in_ready0, 1'b0, "ovf_in_ready");
      @(negedge clk);
    end
    in_valid = 1'b0;
    checks++;
    if (cap0.size() != 0) begin
      errors++;
      $display("FAIL ovf_we: got %0d writes, expected 0", cap0.size());
    end
  endtask

  task automatic test_random_images(input int n_min, input int n_max, input int reps, input string name);
    bq_t b;
    wq_t e;
    for (int r = 0; r < reps; r++) begin
      cap0 = {};
      make_image($urandom_range(n_max, n_min), 32'h0, b, e);
      pulse_start(1'b0, 8'h00);
      send_bytes(b, 30);
      @(negedge clk);
      check_bit(done0, 1'b1, {name, "_done"});
      compare_writes(cap0, e, name);
    end
  endtask

  task automatic test_reset_mid_word();
    bq_t b, part;
    wq_t e;
    make_image(4, 32'h0, b, e);
    part = b[0:7];
    pulse_start(1'b0, 8'h00);
    send_bytes(part, 20);
    reset = 1'b1;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    reset = 1'b0;
    cap0 = {};
    make_image(4, 32'h0, b, e);
    pulse_start(1'b0, 8'h00);
    send_bytes(b, 20);
    @(negedge clk);
    check_bit(done0, 1'b1, "midrst_done");
    compare_writes(cap0, e, "midrst");
  endtask

  task automatic test_reload();
    bq_t b;
    wq_t e;
    sel = 1'b1;
    make_image(1, 32'h100, b, e);
    pulse_start(1'b0, 8'h00);
    send_bytes(b, 0);
    @(negedge clk);
    check_bit(done1, 1'b1, "reload_first_done");
    cap1 = {};
    make_image(1, 32'h100, b, e);
    // The header's first byte rides along with start; it must wait until LEN0.
    pulse_start(1'b1, b[0]);
    check_bit(done1, 1'b0, "reload_done_clear");
    check_bit(cpu_hold1, 1'b1, "reload_cpu_hold");
    send_bytes(b, 0);
    @(negedge clk);
    check_bit(done1, 1'b1, "reload_done");
    compare_writes(cap1, e, "reload");
    sel = 1'b0;
  endtask

  initial begin
    test_reset();
    test_nominal(0, "nominal");
    test_nominal(50, "backpressure");
    test_zero_count();
    test_overflow();
    test_random_images(1, 8, 6, "random");
    test_random_images(64, 64, 1, "max_words");
    test_reset_mid_word();
    test_reload();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
